// File: rtl/atomik_tx_scheduler.sv
// -----------------------------------------------------------------------------
// atomik_tx_scheduler
//
// Shares the single UART TX pin among NUM_REQ (1..4) on-chip requesters.
// An idle scheduler grants one requester per frame in round-robin order. It
// latches that requester's 32-bit word, wraps it in a fixed frame and shifts
// it out as 8N1 UART:
//     0xA5, {6'b0, grant_id}, data[31:24], data[23:16], data[15:8], data[7:0]
// With ATOMIK_TX_CHECKSUM_EN defined, a 7th byte follows data[7:0]. It is the
// XOR of the ID byte and the four data bytes; 0xA5 is not part of it.
//
// Ports:
//   clk        in   system (core) clock
//   rst        in   asynchronous, active-high reset
//   req        in   [NUM_REQ]     per-requester request level
//   req_data   in   [32*NUM_REQ]  request words, requester i at [32*i +: 32]
//   req_ack    out  [NUM_REQ]     one-cycle pulse: the word has been latched
//   uart_tx    out  serial output, idle high
//   busy       out  high while a frame is in flight
//   grant_id   out  [2]           index of the last granted requester
//   frame_done out  one-cycle pulse after the final stop bit
//
// Optional feature macro: ATOMIK_TX_CHECKSUM_EN (appends the checksum byte).
// -----------------------------------------------------------------------------
module atomik_tx_scheduler #(
    parameter int CLK_FREQ  = 81_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int NUM_REQ   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic                   uart_tx,
    output logic                   busy,
    output logic [1:0]             grant_id,
    output logic                   frame_done
);

    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
`ifdef ATOMIK_TX_CHECKSUM_EN
    localparam logic [2:0] LAST_BYTE = 3'd6;
`else
    localparam logic [2:0] LAST_BYTE = 3'd5;
`endif

    generate
        if (NUM_REQ < 1 || NUM_REQ > 4) begin : g_bad_num_req
            $error("atomik_tx_scheduler: NUM_REQ must be in 1..4");
        end
        if (CPB < 1) begin : g_bad_baud
            $error("atomik_tx_scheduler: BAUD_RATE exceeds CLK_FREQ");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [2:0]        bit_q, bit_n;
    logic [2:0]        byte_q, byte_n;
    logic [1:0]        ptr_q, ptr_n;
    logic [1:0]        gid_q, gid_n;
    logic [NUM_REQ-1:0] ack_q, ack_n;
    logic              tx_q, tx_n;
    logic [31:0]       word_q;

    logic [3:0]        req4;
    logic [127:0]      data4;
    logic [1:0]        win_idx;
    logic              win_vld;
    logic [31:0]       word_sel;
    logic              win_load;
    logic [3:0]        ack4;
    logic [2:0]        nxt;
    logic [2:0]        pos;
    logic [7:0]        byte_v;

    // Byte k of the frame being sent.
    function automatic logic [7:0] frame_byte(input logic [2:0]  idx,
                                              input logic [1:0]  gid,
                                              input logic [31:0] w);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hA5;
            3'd1:    b = {6'b0, gid};
            3'd2:    b = w[31:24];
            3'd3:    b = w[23:16];
            3'd4:    b = w[15:8];
            3'd5:    b = w[7:0];
`ifdef ATOMIK_TX_CHECKSUM_EN
            3'd6:    b = {6'b0, gid} ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
            default: b = 8'hFF;
        endcase
        return b;
    endfunction

    // Round-robin scan: start at the pointer, ascend modulo NUM_REQ, first
    // asserted request wins. Inputs are padded to 4 so indices stay 2 bits.
    always_comb begin : arbitrate
        req4    = '0;
        req4[NUM_REQ-1:0] = req;
        data4   = '0;
        data4[32*NUM_REQ-1:0] = req_data;
        win_idx = '0;
        win_vld = 1'b0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr_q} + 3'(k);
            if (pos >= 3'(NUM_REQ)) begin
                pos = pos - 3'(NUM_REQ);
            end
            if (!win_vld && req4[pos[1:0]]) begin
                win_vld = 1'b1;
                win_idx = pos[1:0];
            end
        end
        case (win_idx)
            2'd0:    word_sel = data4[31:0];
            2'd1:    word_sel = data4[63:32];
            2'd2:    word_sel = data4[95:64];
            default: word_sel = data4[127:96];
        endcase
    end

    always_comb begin : next_state
        state_n  = state_q;
        cnt_n    = cnt_q;
        bit_n    = bit_q;
        byte_n   = byte_q;
        ptr_n    = ptr_q;
        gid_n    = gid_q;
        ack4     = '0;
        win_load = 1'b0;
        nxt      = '0;
        byte_v   = 8'hFF;
        tx_n     = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_n  = S_START;
                    cnt_n    = '0;
                    bit_n    = '0;
                    byte_n   = '0;
                    gid_n    = win_idx;
                    win_load = 1'b1;
                    ack4[win_idx] = 1'b1;
                    nxt   = {1'b0, win_idx} + 3'd1;
                    ptr_n = (nxt >= 3'(NUM_REQ)) ? 2'd0 : nxt[1:0];
                end
            end
            S_START, S_DATA, S_STOP: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_n = cnt_q + 1'b1;
                end else begin
                    cnt_n = '0;
                    if (state_q == S_START) begin
                        state_n = S_DATA;
                        bit_n   = '0;
                    end else if (state_q == S_DATA) begin
                        if (bit_q == 3'd7) begin
                            state_n = S_STOP;
                        end else begin
                            bit_n = bit_q + 3'd1;
                        end
                    end else begin
                        // Stop bit finished: next byte follows with no gap.
                        if (byte_q == LAST_BYTE) begin
                            state_n = S_DONE;
                        end else begin
                            byte_n  = byte_q + 3'd1;
                            state_n = S_START;
                        end
                    end
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        // The line level is registered from the next state so the first
        // start bit appears the cycle right after the grant edge.
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA: begin
                byte_v = frame_byte(byte_n, gid_q, word_q);
                tx_n   = byte_v[bit_n];
            end
            default: tx_n = 1'b1;
        endcase

        ack_n = ack4[NUM_REQ-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            ptr_q   <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bit_q   <= bit_n;
            byte_q  <= byte_n;
            ptr_q   <= ptr_n;
            gid_q   <= gid_n;
            ack_q   <= ack_n;
            tx_q    <= tx_n;
        end
    end

    // Payload register: only meaningful while a frame is in flight.
    always_ff @(posedge clk) begin
        if (win_load) begin
            word_q <= word_sel;
        end
    end

    assign req_ack    = ack_q;
    assign uart_tx    = tx_q;
    assign grant_id   = gid_q;
    assign busy       = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
    assign frame_done = (state_q == S_DONE);

endmodule

// File: tb/tb_atomik_tx_scheduler.sv
module tb_atomik_tx_scheduler;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;
`ifdef ATOMIK_TX_CHECKSUM_EN
    localparam int NBYTES = 7;
`else
    localparam int NBYTES = 6;
`endif
    localparam int FCYC = NBYTES * 10 * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [95:0] req_data;
    logic [2:0]  req_ack;
    logic        uart_tx, busy, frame_done;
    logic [1:0]  grant_id;

    logic [0:0]  req1;
    logic [31:0] data1;
    logic [0:0]  ack1;
    logic        tx1, busy1, fd1;
    logic [1:0]  gid1;

    always #5 clk = ~clk;

    atomik_tx_scheduler #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .NUM_REQ(3)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
        .uart_tx(uart_tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
    );

    atomik_tx_scheduler #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .NUM_REQ(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .req_data(data1), .req_ack(ack1),
        .uart_tx(tx1), .busy(busy1), .grant_id(gid1), .frame_done(fd1)
    );

    int vectors     = 0;
    int miscompares = 0;
    int model_ptr   = 0;

    logic       tx_s   [0:FCYC+1];
    logic       fd_s   [0:FCYC+1];
    logic       busy_s [0:FCYC+1];
    logic [2:0] ack_s  [0:FCYC+1];

    // ---------------- reference model ----------------
    function automatic int rr_pick(input int ptr, input logic [2:0] r);
        for (int k = 0; k < 3; k++) begin
            if (r[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_byte(input int gid, input logic [31:0] w, input int k);
        logic [7:0] id;
        id = 8'(gid);
        case (k)
            0: return 8'hA5;
            1: return id;
            2: return w[31:24];
            3: return w[23:16];
            4: return w[15:8];
            5: return w[7:0];
            default: return id ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        endcase
    endfunction

    // Line level c cycles after the first start-bit edge of a frame.
    function automatic logic exp_line(input int gid, input logic [31:0] w, input int c);
        int bp, p;
        logic [7:0] eb;
        bp = c / CPB;
        p  = bp % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        eb = exp_byte(gid, w, bp / 10);
        return eb[p-1];
    endfunction

    // Number of captured cycles that disagree with the expected frame.
    function automatic int frame_errs(input int gid, input logic [31:0] w);
        int e;
        logic [2:0] oh;
        e  = 0;
        oh = 3'(1 << gid);
        for (int c = 0; c < FCYC; c++) begin
            if (tx_s[c] !== exp_line(gid, w, c)) e++;
            if (busy_s[c] !== 1'b1 || fd_s[c] !== 1'b0) e++;
            if (ack_s[c] !== ((c == 0) ? oh : 3'b000)) e++;
        end
        if (fd_s[FCYC] !== 1'b1 || busy_s[FCYC] !== 1'b0 || tx_s[FCYC] !== 1'b1) e++;
        if (fd_s[FCYC+1] !== 1'b0 || busy_s[FCYC+1] !== 1'b0 || tx_s[FCYC+1] !== 1'b1) e++;
        if (ack_s[FCYC] !== 3'b000 || ack_s[FCYC+1] !== 3'b000) e++;
        return e;
    endfunction

    function automatic logic [7:0] decode_byte(input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = tx_s[(k*10 + 1 + j)*CPB + CPB/2];
        return b;
    endfunction

    // ---------------- utilities ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grab(input int from, input int to);
        for (int c = from; c < to; c++) begin
            tx_s[c]   = uart_tx;
            fd_s[c]   = frame_done;
            busy_s[c] = busy;
            ack_s[c]  = req_ack;
            tick();
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            if (req_ack !== 3'b000) ok = 1'b1;
            else tick();
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: no req_ack within 2000 cycles (req=%b)", req);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_ptr = 0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; req = '0; req_data = '0; req1 = '0; data1 = '0;
        tick();
        tick();
        vectors += 5;
        if (uart_tx !== 1'b1)     begin miscompares++; $display("FAIL rst_tx: got %b want 1", uart_tx); end
        if (busy !== 1'b0)        begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        if (req_ack !== 3'b000)   begin miscompares++; $display("FAIL rst_ack: got %b want 000", req_ack); end
        if (frame_done !== 1'b0)  begin miscompares++; $display("FAIL rst_done: got %b want 0", frame_done); end
        if (grant_id !== 2'd0)    begin miscompares++; $display("FAIL rst_gid: got %0d want 0", grant_id); end
        rst = 1'b0;
        model_ptr = 0;
        tick();
    endtask

    task automatic test_single();
        bit ok;
        int e, exp_id;
        logic [7:0] tp [6];
        logic [7:0] got;
        tp = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
        req_data[31:0] = 32'h1234_5678;
        req = 3'b001;
        wait_ack(ok);
        if (!ok) return;
        exp_id = rr_pick(model_ptr, 3'b001);
        model_ptr = (exp_id + 1) % 3;
        req = 3'b000;
        vectors += 3;
        if (req_ack !== 3'b001)  begin miscompares++; $display("FAIL single_ack: got %b want 001", req_ack); end
        if (grant_id !== 2'(exp_id)) begin miscompares++; $display("FAIL single_gid: got %0d want %0d", grant_id, exp_id); end
        if (uart_tx !== 1'b0)    begin miscompares++; $display("FAIL single_first_start: got %b want 0", uart_tx); end
        grab(0, FCYC + 2);
        for (int k = 0; k < 6; k++) begin
            got = decode_byte(k);
            vectors++;
            if (got !== tp[k]) begin miscompares++; $display("FAIL single_byte%0d: got %02h want %02h", k, got, tp[k]); end
        end
        vectors++;
        if (fd_s[FCYC] !== 1'b1) begin miscompares++; $display("FAIL single_done_pos: frame_done at +%0d is %b want 1", FCYC, fd_s[FCYC]); end
        e = frame_errs(exp_id, 32'h1234_5678);
        vectors++;
        if (e !== 0) begin miscompares++; $display("FAIL single_frame: %0d bad cycles, want 0", e); end
    endtask

    task automatic test_all_three();
        bit ok;
        int e, exp_id;
        logic [2:0] pend;
        logic [31:0] w [3];
        w = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
        do_reset();
        req_data = {w[2], w[1], w[0]};
        req  = 3'b111;
        pend = 3'b111;
        for (int f = 0; f < 3; f++) begin
            wait_ack(ok);
            if (!ok) return;
            exp_id = rr_pick(model_ptr, pend);
            model_ptr = (exp_id + 1) % 3;
            pend[exp_id] = 1'b0;
            req[exp_id]  = 1'b0;
            vectors += 2;
            if (req_ack !== 3'(1 << exp_id)) begin miscompares++; $display("FAIL three_ack%0d: got %b want %b", f, req_ack, 3'(1 << exp_id)); end
            if (grant_id !== 2'(exp_id)) begin miscompares++; $display("FAIL three_gid%0d: got %0d want %0d", f, grant_id, exp_id); end
            grab(0, FCYC + 2);
            e = frame_errs(exp_id, w[exp_id]);
            vectors++;
            if (e !== 0) begin miscompares++; $display("FAIL three_frame%0d: %0d bad cycles, want 0", f, e); end
        end
        e = 0;
        for (int c = 0; c < 50; c++) begin
            if (req_ack !== 3'b000 || busy !== 1'b0) e++;
            tick();
        end
        vectors++;
        if (e !== 0) begin miscompares++; $display("FAIL three_extra_ack: %0d busy/ack cycles after last frame, want 0", e); end
    endtask

    task automatic test_rr_hold();
        bit ok;
        int e, exp_id;
        logic [2:0] pend;
        logic [31:0] w0, w2;
        w0 = $urandom;
        w2 = $urandom;
        req_data[95:64] = w2;
        req_data[31:0]  = w0;
        req  = 3'b100;
        pend = 3'b100;
        for (int f = 0; f < 3; f++) begin
            wait_ack(ok);
            if (!ok) return;
            exp_id = rr_pick(model_ptr, pend);
            model_ptr = (exp_id + 1) % 3;
            vectors += 2;
            if (req_ack !== 3'(1 << exp_id)) begin miscompares++; $display("FAIL hold_ack%0d: got %b want %b", f, req_ack, 3'(1 << exp_id)); end
            if (grant_id !== 2'(exp_id)) begin miscompares++; $display("FAIL hold_gid%0d: got %0d want %0d", f, grant_id, exp_id); end
            // Requester 2 keeps its request up through its first grant.
            if (f != 0) begin
                req[exp_id]  = 1'b0;
                pend[exp_id] = 1'b0;
            end
            if (f == 0) begin
                grab(0, 200);
                req[0]  = 1'b1;
                pend[0] = 1'b1;
                grab(200, FCYC + 2);
            end else begin
                grab(0, FCYC + 2);
            end
            e = frame_errs(exp_id, (exp_id == 0) ? w0 : w2);
            vectors++;
            if (e !== 0) begin miscompares++; $display("FAIL hold_frame%0d: %0d bad cycles, want 0", f, e); end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int e, exp_id;
        logic [31:0] w1, w2;
        w1 = $urandom;
        req_data[63:32] = w1;
        req = 3'b010;
        wait_ack(ok);
        if (!ok) return;
        exp_id = rr_pick(model_ptr, 3'b010);
        model_ptr = (exp_id + 1) % 3;
        req = 3'b000;
        grab(0, 3*10*CPB + 45);
        #3;
        rst = 1'b1;
        #1;
        vectors += 5;
        if (uart_tx !== 1'b1)    begin miscompares++; $display("FAIL mid_rst_tx: got %b want 1", uart_tx); end
        if (busy !== 1'b0)       begin miscompares++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL mid_rst_done: got %b want 0", frame_done); end
        if (req_ack !== 3'b000)  begin miscompares++; $display("FAIL mid_rst_ack: got %b want 000", req_ack); end
        if (grant_id !== 2'd0)   begin miscompares++; $display("FAIL mid_rst_gid: got %0d want 0", grant_id); end
        model_ptr = 0;
        tick();
        rst = 1'b0;
        e = 0;
        for (int c = 0; c < 150; c++) begin
            if (uart_tx !== 1'b1 || busy !== 1'b0) e++;
            tick();
        end
        vectors++;
        if (e !== 0) begin miscompares++; $display("FAIL mid_no_resend: %0d active cycles, want 0", e); end
        w1 = $urandom;
        w2 = $urandom;
        req_data[63:32] = w1;
        req_data[95:64] = w2;
        req = 3'b110;
        wait_ack(ok);
        if (!ok) return;
        exp_id = rr_pick(model_ptr, 3'b110);
        model_ptr = (exp_id + 1) % 3;
        req = 3'b000;
        vectors++;
        if (req_ack !== 3'(1 << exp_id)) begin miscompares++; $display("FAIL mid_ptr_reset: ack %b want %b", req_ack, 3'(1 << exp_id)); end
        grab(0, FCYC + 2);
        e = frame_errs(exp_id, (exp_id == 1) ? w1 : w2);
        vectors++;
        if (e !== 0) begin miscompares++; $display("FAIL mid_new_frame: %0d bad cycles, want 0", e); end
    endtask

    task automatic test_random();
        bit ok;
        int e, exp_id;
        logic [2:0] pend;
        logic [31:0] w [3];
        for (int r = 0; r < 4; r++) begin
            pend = 3'($urandom_range(1, 7));
            for (int i = 0; i < 3; i++) w[i] = $urandom;
            req_data = {w[2], w[1], w[0]};
            req = pend;
            while (pend != 3'b000) begin
                wait_ack(ok);
                if (!ok) return;
                exp_id = rr_pick(model_ptr, pend);
                model_ptr = (exp_id + 1) % 3;
                pend[exp_id] = 1'b0;
                req[exp_id]  = 1'b0;
                vectors += 2;
                if (req_ack !== 3'(1 << exp_id)) begin miscompares++; $display("FAIL rand%0d_ack: got %b want %b", r, req_ack, 3'(1 << exp_id)); end
                if (grant_id !== 2'(exp_id)) begin miscompares++; $display("FAIL rand%0d_gid: got %0d want %0d", r, grant_id, exp_id); end
                grab(0, FCYC + 2);
                e = frame_errs(exp_id, w[exp_id]);
                vectors++;
                if (e !== 0) begin miscompares++; $display("FAIL rand%0d_frame: %0d bad cycles, want 0 (word %08h)", r, e, w[exp_id]); end
            end
        end
    endtask

    task automatic test_num_req1();
        int acks, fds, n;
        bit ok;
        data1 = $urandom;
        req1  = 1'b1;
        tick();
        req1 = 1'b0;
        vectors += 3;
        if (ack1 !== 1'b1)  begin miscompares++; $display("FAIL one_ack: got %b want 1", ack1); end
        if (tx1 !== 1'b0)   begin miscompares++; $display("FAIL one_start: got %b want 0", tx1); end
        if (gid1 !== 2'd0)  begin miscompares++; $display("FAIL one_gid: got %0d want 0", gid1); end
        tick();
        acks = 0;
        fds  = 0;
        for (int c = 0; c < FCYC + 200; c++) begin
            req1 = (c == 100 || c == 300) ? 1'b1 : 1'b0;
            if (ack1 === 1'b1) acks++;
            if (fd1 === 1'b1) fds++;
            tick();
        end
        vectors += 3;
        if (acks !== 0)    begin miscompares++; $display("FAIL one_busy_pulses: %0d extra acks, want 0", acks); end
        if (fds !== 1)     begin miscompares++; $display("FAIL one_done_count: got %0d want 1", fds); end
        if (busy1 !== 1'b0 || tx1 !== 1'b1) begin miscompares++; $display("FAIL one_idle: busy=%b tx=%b want 0/1", busy1, tx1); end
        req1 = 1'b1;
        ok = 1'b0;
        for (n = 0; n < 50 && !ok; n++) begin
            if (ack1 === 1'b1) ok = 1'b1;
            else tick();
        end
        req1 = 1'b0;
        vectors += 2;
        if (!ok) begin miscompares++; $display("FAIL one_second_ack: got none want 1"); end
        if (gid1 !== 2'd0) begin miscompares++; $display("FAIL one_second_gid: got %0d want 0", gid1); end
        fds = 0;
        for (int c = 0; c < FCYC + 2; c++) begin
            if (fd1 === 1'b1) fds++;
            tick();
        end
        vectors++;
        if (fds !== 1) begin miscompares++; $display("FAIL one_second_done: got %0d want 1", fds); end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        req_data = '0;
        req1 = '0;
        data1 = '0;
        test_reset();
        test_single();
        test_all_three();
        test_rr_hold();
        test_reset_midframe();
        test_random();
        test_num_req1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
